// File: rtl/rk4_lbe_axis_block_detector.sv
// rk4_lbe_axis_block_detector
// Watches the AXI-Stream handshakes of an HLS top level and raises a
// per-channel block flag once a channel has stalled for STALL_THRESH
// consecutive cycles. The flags feed the deadlock monitor. The first
// channel to block is latched for debug readout.
//
// Optional build macro: RK4_LBE_STALL_HIST_EN adds per-channel block-entry
// history counters, readable through hist_sel / hist_cnt.
//
// Stall meaning per channel:
//   output stream (ch_dir=1): the core offers data that is not taken
//                             (valid & ~ready).
//   input stream  (ch_dir=0): the core wants data that is not offered
//                             (ready & ~valid).
//   A completed transfer (valid & ready) and an idle channel
//   (~valid & ~ready) are never stalls.
//
// Every output is a flop, so there is no combinational path from any
// input to any output.
module rk4_lbe_axis_block_detector #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 16,
  parameter int STALL_THRESH = 1024,
  parameter int ID_W         = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_dir,
  input  logic              clear_first,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              any_block,
  output logic              first_valid,
  output logic [ID_W-1:0]   first_ch
`ifdef RK4_LBE_STALL_HIST_EN
  ,
  input  logic [ID_W-1:0]   hist_sel,
  output logic [15:0]       hist_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_BLOCK = 2'd2
  } ch_state_e;

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);

  // Per-channel FSM state and stall counter.
  ch_state_e        state_q [NUM_CH];
  ch_state_e        state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] block_d;
  logic [NUM_CH-1:0] entry;      // channel enters BLOCK on this edge
  logic [ID_W-1:0]   entry_idx;  // lowest entering channel

  logic [NUM_CH-1:0] block_q;
  logic              any_block_q;
  logic              first_valid_q, first_valid_d;
  logic [ID_W-1:0]   first_ch_q, first_ch_d;

  // Decode the direction-dependent stall condition per channel.
  always_comb begin
    stall = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      stall[i] = ch_dir[i] ? (ch_valid[i] & ~ch_ready[i])
                           : (ch_ready[i] & ~ch_valid[i]);
    end
  end

  // Next-state and counter logic for every channel FSM.
  always_comb begin
    block_d = '0;
    entry   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!enable) begin
        state_d[i] = ST_RUN;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_RUN: begin
            if (stall[i]) begin
              cnt_d[i]   = CNT_W'(1);
              // A threshold of one skips the pending phase entirely.
              state_d[i] = (THRESH == CNT_W'(1)) ? ST_BLOCK : ST_PEND;
            end
          end
          ST_PEND: begin
            if (!stall[i]) begin
              state_d[i] = ST_RUN;
              cnt_d[i]   = '0;
            end else begin
              // The counter stops at THRESH because reaching it leaves PEND.
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
              if (cnt_d[i] == THRESH) begin
                state_d[i] = ST_BLOCK;
              end
            end
          end
          ST_BLOCK: begin
            if (!stall[i]) begin
              state_d[i] = ST_RUN;
              cnt_d[i]   = '0;
            end
          end
          default: begin
            state_d[i] = ST_RUN;
            cnt_d[i]   = '0;
          end
        endcase
      end
      block_d[i] = (state_d[i] == ST_BLOCK);
      entry[i]   = block_d[i] & (state_q[i] != ST_BLOCK);
    end
  end

  // Pick the lowest-numbered channel that enters BLOCK this cycle.
  always_comb begin
    entry_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (entry[i]) begin
        entry_idx = ID_W'(i);
      end
    end
  end

  // First-blocked latch: a fresh capture takes priority over a clear.
  always_comb begin
    first_valid_d = first_valid_q;
    first_ch_d    = first_ch_q;
    if ((!first_valid_q || clear_first) && (|entry)) begin
      first_valid_d = 1'b1;
      first_ch_d    = entry_idx;
    end else if (clear_first) begin
      first_valid_d = 1'b0;
      first_ch_d    = '0;
    end
  end

  // State, counter, flag and latch registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_RUN;
        cnt_q[i]   <= '0;
      end
      block_q       <= '0;
      any_block_q   <= 1'b0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      block_q       <= block_d;
      any_block_q   <= |block_d;
      first_valid_q <= first_valid_d;
      first_ch_q    <= first_ch_d;
    end
  end

  assign axis_block_sigs = block_q;
  assign any_block       = any_block_q;
  assign first_valid     = first_valid_q;
  assign first_ch        = first_ch_q;

`ifdef RK4_LBE_STALL_HIST_EN
  logic [15:0] hist_q [NUM_CH];
  logic [15:0] hist_sel_val;
  logic [15:0] hist_cnt_q;

  // Index compare keeps out-of-range selects reading zero.
  always_comb begin
    hist_sel_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hist_sel == ID_W'(i)) begin
        hist_sel_val = hist_q[i];
      end
    end
  end

  // Saturating block-entry counters and the registered readout.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hist_q[i] <= '0;
      end
      hist_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (entry[i] && (hist_q[i] != 16'hFFFF)) begin
          hist_q[i] <= hist_q[i] + 16'd1;
        end
      end
      hist_cnt_q <= hist_sel_val;
    end
  end

  assign hist_cnt = hist_cnt_q;
`endif

endmodule

// File: tb/tb_rk4_lbe_axis_block_detector.sv
// Directed bench for rk4_lbe_axis_block_detector with NUM_CH=2,
// STALL_THRESH=4. Inputs change on the falling edge; outputs are
// checked on the following falling edge, i.e. after the rising edge
// that sampled those inputs.
module tb_rk4_lbe_axis_block_detector;

  localparam int NUM_CH = 2;
  localparam int ID_W   = 5;

  logic              clock;
  logic              reset;
  logic              enable;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] ch_dir;
  logic              clear_first;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              any_block;
  logic              first_valid;
  logic [ID_W-1:0]   first_ch;
`ifdef RK4_LBE_STALL_HIST_EN
  logic [ID_W-1:0]   hist_sel;
  logic [15:0]       hist_cnt;
`endif

  int total;
  int bad;

  rk4_lbe_axis_block_detector #(
    .NUM_CH(NUM_CH), .CNT_W(16), .STALL_THRESH(4), .ID_W(ID_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .ch_valid(ch_valid),
    .ch_ready(ch_ready),
    .ch_dir(ch_dir),
    .clear_first(clear_first),
    .axis_block_sigs(axis_block_sigs),
    .any_block(any_block),
    .first_valid(first_valid),
    .first_ch(first_ch)
`ifdef RK4_LBE_STALL_HIST_EN
    ,
    .hist_sel(hist_sel),
    .hist_cnt(hist_cnt)
`endif
  );

  // Clock generation.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges and land on the next falling edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clear();
    clear_first = 1'b1;
    tick(1);
    clear_first = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    enable      = 1'b1;
    ch_valid    = 2'b00;
    ch_ready    = 2'b00;
    ch_dir      = 2'b11;
    clear_first = 1'b0;
`ifdef RK4_LBE_STALL_HIST_EN
    hist_sel    = '0;
`endif
    @(negedge clock);
    tick(2);
    reset = 1'b0;
    chk("rst_block", 32'(axis_block_sigs), 32'h0);
    chk("rst_any",   32'(any_block),       32'h0);
    chk("rst_fv",    32'(first_valid),     32'h0);
    chk("rst_fc",    32'(first_ch),        32'h0);

    // Output stall on ch0 for six cycles, then a transfer.
    ch_valid = 2'b01; ch_ready = 2'b00;
    tick(3);
    chk("out_3edges", 32'(axis_block_sigs), 32'h0);
    tick(1);
    chk("out_4edges", 32'(axis_block_sigs), 32'h1);
    chk("out_any",    32'(any_block),       32'h1);
    chk("out_fv",     32'(first_valid),     32'h1);
    chk("out_fc",     32'(first_ch),        32'h0);
    tick(2);
    chk("out_hold", 32'(axis_block_sigs), 32'h1);
    ch_ready = 2'b01;
    tick(1);
    chk("out_drop",     32'(axis_block_sigs), 32'h0);
    chk("out_any_drop", 32'(any_block),       32'h0);
    chk("out_fv_sticky", 32'(first_valid),    32'h1);
    ch_valid = 2'b00; ch_ready = 2'b00;
    pulse_clear();
    chk("clr_fv", 32'(first_valid), 32'h0);

    // Short stalls on ch1 separated by a transfer.
    ch_valid = 2'b10; ch_ready = 2'b00;
    tick(3);
    chk("short_a", 32'(axis_block_sigs), 32'h0);
    ch_ready = 2'b10;
    tick(1);
    ch_ready = 2'b00;
    tick(3);
    chk("short_b", 32'(axis_block_sigs), 32'h0);
    tick(1);
    chk("short_4th", 32'(axis_block_sigs), 32'h2);
    chk("short_fc",  32'(first_ch),        32'h1);
    ch_valid = 2'b00;
    tick(1);
    chk("short_rel", 32'(axis_block_sigs), 32'h0);
    pulse_clear();

    // Input starvation on ch1, then a long idle period.
    ch_dir = 2'b01;
    ch_ready = 2'b10; ch_valid = 2'b00;
    tick(3);
    chk("in_3", 32'(axis_block_sigs), 32'h0);
    tick(1);
    chk("in_4", 32'(axis_block_sigs), 32'h2);
    ch_ready = 2'b00;
    tick(1);
    chk("in_rel", 32'(axis_block_sigs), 32'h0);
    tick(100);
    chk("idle_100", 32'(axis_block_sigs), 32'h0);
    chk("idle_any", 32'(any_block),       32'h0);
    pulse_clear();
    chk("idle_fv_clr", 32'(first_valid), 32'h0);

    // Simultaneous block on both output channels.
    ch_dir = 2'b11;
    ch_valid = 2'b11; ch_ready = 2'b00;
    tick(3);
    chk("sim_3", 32'(axis_block_sigs), 32'h0);
    tick(1);
    chk("sim_4",   32'(axis_block_sigs), 32'h3);
    chk("sim_any", 32'(any_block),       32'h1);
    chk("sim_fc",  32'(first_ch),        32'h0);
    ch_valid = 2'b00;
    tick(1);
    chk("sim_rel", 32'(axis_block_sigs), 32'h0);
    // Clear while ch1 starts a new stall; it blocks a few edges later.
    ch_valid = 2'b10;
    clear_first = 1'b1;
    tick(1);
    clear_first = 1'b0;
    tick(1);
    chk("reblk_fv0", 32'(first_valid), 32'h0);
    tick(2);
    chk("reblk_blk", 32'(axis_block_sigs), 32'h2);
    chk("reblk_fv",  32'(first_valid),     32'h1);
    chk("reblk_fc",  32'(first_ch),        32'h1);
    // Clear on the same edge ch0 enters BLOCK: the capture wins.
    ch_valid = 2'b11;
    tick(3);
    clear_first = 1'b1;
    tick(1);
    clear_first = 1'b0;
    chk("cw_blk", 32'(axis_block_sigs), 32'h3);
    chk("cw_fv",  32'(first_valid),     32'h1);
    chk("cw_fc",  32'(first_ch),        32'h0);
    ch_valid = 2'b00;
    tick(1);
    pulse_clear();

    // Enable dropped on the third edge of a stall.
    ch_valid = 2'b01;
    tick(2);
    enable = 1'b0;
    tick(1);
    chk("en_abort", 32'(axis_block_sigs), 32'h0);
    enable = 1'b1;
    tick(3);
    chk("en_re3", 32'(axis_block_sigs), 32'h0);
    tick(1);
    chk("en_re4", 32'(axis_block_sigs), 32'h1);
    chk("en_fv",  32'(first_valid),     32'h1);
    ch_valid = 2'b00;
    tick(1);

    // Reset pulsed on the third edge of a stall.
    ch_valid = 2'b01;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rs_blk", 32'(axis_block_sigs), 32'h0);
    chk("rs_fv",  32'(first_valid),     32'h0);
    chk("rs_fc",  32'(first_ch),        32'h0);
    tick(3);
    chk("rs_re3", 32'(axis_block_sigs), 32'h0);
    tick(1);
    chk("rs_re4", 32'(axis_block_sigs), 32'h1);
    ch_valid = 2'b00;
    tick(1);

`ifdef RK4_LBE_STALL_HIST_EN
    // ch0 has one entry since reset; add two more episodes.
    for (int e = 0; e < 2; e++) begin
      ch_valid = 2'b01;
      tick(4);
      ch_valid = 2'b00;
      tick(1);
    end
    hist_sel = 5'd0;
    tick(1);
    chk("hist_ch0", 32'(hist_cnt), 32'd3);
    hist_sel = 5'd1;
    tick(1);
    chk("hist_ch1", 32'(hist_cnt), 32'd0);
    hist_sel = 5'd3;
    tick(1);
    chk("hist_oor", 32'(hist_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
